// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: drives a single-bit output through up to NUM_SEG programmable
// level/duration segments. The configuration is captured when start is accepted.
module pattern_seq_gen #(
  parameter int UNIT_COUNT = 27000,
  parameter int NUM_SEG    = 8,
  parameter int LEN_W      = 4,
  parameter int IDX_W      = $clog2(NUM_SEG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [IDX_W-1:0]         seg_count,
  input  logic [NUM_SEG*LEN_W-1:0] seg_len,
  input  logic [NUM_SEG-1:0]       seg_level,
  output logic                     sig,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         seg_idx
);

  localparam int                TICK_W    = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_COUNT - 1);
  localparam logic [IDX_W-1:0]  SEG_MAX   = IDX_W'(NUM_SEG);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state_reg,     state_next;
  logic [TICK_W-1:0]        tick_reg,      tick_next;
  logic [LEN_W-1:0]         unit_reg,      unit_next;
  logic [IDX_W-1:0]         idx_reg,       idx_next;
  logic [IDX_W-1:0]         cnt_reg,       cnt_next;
  logic [NUM_SEG*LEN_W-1:0] cfg_len_reg,   cfg_len_next;
  logic [NUM_SEG-1:0]       cfg_level_reg, cfg_level_next;
  logic                     sig_reg,       sig_next;
  logic                     busy_reg,      busy_next;
  logic                     done_reg,      done_next;

  // Per-segment view of the latched lengths.
  logic [LEN_W-1:0]   len_arr [NUM_SEG];
  logic [NUM_SEG-1:0] len_zero;

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      assign len_arr[gi]  = cfg_len_reg[gi*LEN_W +: LEN_W];
      assign len_zero[gi] = (len_arr[gi] == '0);
    end
  endgenerate

  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] cnt_in;
  logic [LEN_W-1:0] cur_len;
  logic             nxt_zero;
  logic             nxt_level;
  logic             last_seg;
  logic             unit_end;
  logic             tick_end;
  logic             seg_end;
  logic             in_zero0;

  assign idx_inc  = idx_reg + IDX_W'(1);
  assign cnt_in   = (seg_count > SEG_MAX) ? SEG_MAX : seg_count;
  assign in_zero0 = (seg_len[LEN_W-1:0] == '0);

  // Select the current segment's length and the following segment's attributes.
  always_comb begin
    cur_len   = '0;
    nxt_zero  = 1'b0;
    nxt_level = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_len = len_arr[i];
      end
      if (idx_inc == IDX_W'(i)) begin
        nxt_zero  = len_zero[i];
        nxt_level = cfg_level_reg[i];
      end
    end
  end

  assign last_seg = (idx_inc == cnt_reg);
  assign tick_end = (tick_reg == TICK_LAST);
  assign unit_end = (unit_reg == (cur_len - LEN_W'(1)));
  // A zero-length segment ends on its first cycle.
  assign seg_end  = (cur_len == '0) || (unit_end && tick_end);

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    unit_next      = unit_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    cfg_len_next   = cfg_len_reg;
    cfg_level_next = cfg_level_reg;
    sig_next       = sig_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        sig_next  = 1'b0;
        busy_next = 1'b0;
        idx_next  = '0;
        tick_next = '0;
        unit_next = '0;
        if (!stop && start && (seg_count != '0)) begin
          state_next     = RUN;
          busy_next      = 1'b1;
          cnt_next       = cnt_in;
          cfg_len_next   = seg_len;
          cfg_level_next = seg_level;
          // Zero-length first segment holds the idle level.
          sig_next       = in_zero0 ? 1'b0 : seg_level[0];
        end
      end

      RUN: begin
        if (stop) begin
          state_next = IDLE;
          sig_next   = 1'b0;
          busy_next  = 1'b0;
          idx_next   = '0;
          tick_next  = '0;
          unit_next  = '0;
        end else if (seg_end) begin
          tick_next = '0;
          unit_next = '0;
          if (last_seg) begin
            if (loop_en) begin
              idx_next = '0;
              sig_next = len_zero[0] ? sig_reg : cfg_level_reg[0];
            end else begin
              state_next = IDLE;
              sig_next   = 1'b0;
              busy_next  = 1'b0;
              done_next  = 1'b1;
              idx_next   = '0;
            end
          end else begin
            idx_next = idx_inc;
            sig_next = nxt_zero ? sig_reg : nxt_level;
          end
        end else if (tick_end) begin
          tick_next = '0;
          unit_next = unit_reg + LEN_W'(1);
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tick_reg      <= '0;
      unit_reg      <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      cfg_len_reg   <= '0;
      cfg_level_reg <= '0;
      sig_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      unit_reg      <= unit_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      cfg_len_reg   <= cfg_len_next;
      cfg_level_reg <= cfg_level_next;
      sig_reg       <= sig_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign sig     = sig_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign seg_idx = idx_reg;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Bench for pattern_seq_gen: table vectors, hand-written corner sequences and random
// configurations compared against a per-cycle waveform model built from segment rules.
module tb_pattern_seq_gen;
  localparam int UC = 4;
  localparam int NS = 8;
  localparam int LW = 4;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [IW-1:0]    seg_count = '0;
  logic [NS*LW-1:0] seg_len = '0;
  logic [NS-1:0]    seg_level = '0;
  logic             sig;
  logic             busy;
  logic             done;
  logic [IW-1:0]    seg_idx;

  int checks = 0;
  int failures = 0;

  logic         exp_sig[$];
  int           exp_idx[$];
  logic [255:0] cap;

  typedef struct {
    logic [IW-1:0] cnt;
    logic [31:0]   len;
    logic [7:0]    lvl;
    int            cycles;
  } vec_t;
  vec_t vecs[6];

  pattern_seq_gen #(.UNIT_COUNT(UC), .NUM_SEG(NS), .LEN_W(LW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .seg_count(seg_count), .seg_len(seg_len), .seg_level(seg_level),
    .sig(sig), .busy(busy), .done(done), .seg_idx(seg_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected waveform: each segment lasts max(L*UC,1) cycles; zero length holds the level.
  function automatic void build_model(input logic [IW-1:0] cnt, input logic [31:0] len,
                                      input logic [7:0] lvl);
    int   n;
    logic prev;
    n = (int'(cnt) > NS) ? NS : int'(cnt);
    prev = 1'b0;
    exp_sig.delete();
    exp_idx.delete();
    for (int i = 0; i < n; i++) begin
      int   l;
      int   cyc;
      logic s;
      l   = int'(len[i*4 +: 4]);
      cyc = (l == 0) ? 1 : l * UC;
      s   = (l == 0) ? prev : lvl[i];
      repeat (cyc) begin
        exp_sig.push_back(s);
        exp_idx.push_back(i);
      end
      prev = s;
    end
  endfunction

  task automatic set_cfg(input logic [IW-1:0] c, input logic [31:0] l, input logic [7:0] v);
    seg_count = c;
    seg_len   = l;
    seg_level = v;
    build_model(c, l, v);
  endtask

  // Called at a negedge; returns at the negedge where cycle 0 of the pass is visible.
  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_wave(input string name, input int k);
    int j;
    j = k % exp_sig.size();
    chk($sformatf("%s_wave[%0d]", name, k), 64'({sig, busy, done, seg_idx}),
        64'({exp_sig[j], 1'b1, 1'b0, IW'(exp_idx[j])}));
  endtask

  task automatic run_pass(input string name, input int exp_cycles, input int disturb_at,
                          input bit chain);
    int k;
    k = 0;
    cap = '0;
    launch();
    while (busy === 1'b1 && k < 400) begin
      if (k < exp_sig.size()) chk_wave(name, k);
      if (k < 256) cap[k] = sig;
      if (k == disturb_at) begin
        seg_count = 4'd3;
        seg_len   = ~seg_len;
        seg_level = ~seg_level;
        start     = 1'b1;
      end
      if (k == disturb_at + 1) start = 1'b0;
      k++;
      @(negedge clk);
    end
    chk({name, "_busy_len"}, 64'(k), 64'(exp_cycles));
    chk({name, "_done"}, 64'({sig, busy, done, seg_idx}), 64'({1'b0, 1'b0, 1'b1, IW'(0)}));
    if (!chain) begin
      @(negedge clk);
      chk({name, "_done_once"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    logic [14:0]   pat;
    logic [59:0]   exp60;
    logic [IW-1:0] rc;
    logic [31:0]   rl;
    logic [7:0]    rv;

    vecs[0] = '{4'd8,  32'h15321111, 8'h55, 60};
    vecs[1] = '{4'd3,  32'h00000302, 8'h01, 21};
    vecs[2] = '{4'd12, 32'h11111111, 8'hAA, 32};
    vecs[3] = '{4'd1,  32'h00000000, 8'h01, 1};
    vecs[4] = '{4'd2,  32'h0000000F, 8'h03, 61};
    vecs[5] = '{4'd8,  32'h00000000, 8'hFF, 8};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({sig, busy, done, seg_idx}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_release", 64'({sig, busy, done, seg_idx}), 64'(0));

    // Table-driven one-shot passes.
    pat = 15'b101011000111110;
    for (int i = 0; i < 60; i++) exp60[i] = pat[14 - i/4];
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].cnt, vecs[v].len, vecs[v].lvl);
      run_pass($sformatf("vec%0d", v), vecs[v].cycles, -1, 1'b0);
      if (v == 0) chk("oneshot_pattern", 64'(cap[59:0]), 64'(exp60));
    end

    // seg_count=0 with start held stays idle.
    set_cfg(4'd0, 32'h11111111, 8'hFF);
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("zero_count_idle", 64'({sig, busy, done, seg_idx}), 64'(0));
    end
    start = 1'b0;

    // stop in IDLE overrides start.
    set_cfg(vecs[0].cnt, vecs[0].len, vecs[0].lvl);
    stop  = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stop_over_start", 64'(busy), 64'(0));
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    // Continuous mode over three passes, then loop_en dropped during pass 4.
    loop_en = 1'b1;
    launch();
    for (int k = 0; k < 240; k++) begin
      if (k > 0) @(negedge clk);
      chk_wave("loop", k);
      if (k == 200) loop_en = 1'b0;
    end
    @(negedge clk);
    chk("loop_end_done", 64'({sig, busy, done, seg_idx}), 64'({1'b0, 1'b0, 1'b1, IW'(0)}));
    @(negedge clk);
    chk("loop_done_once", 64'(done), 64'(0));

    // Abort during segment 5, then replay from segment 0.
    launch();
    for (int k = 0; k < 26; k++) begin
      if (k > 0) @(negedge clk);
      chk_wave("prestop", k);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_idle", 64'({sig, busy, done, seg_idx}), 64'(0));
    @(negedge clk);
    chk("stop_no_done", 64'({sig, busy, done}), 64'(0));
    run_pass("replay", 60, -1, 1'b0);

    // Config change + start during RUN ignored; back-to-back start in the done cycle.
    set_cfg(vecs[0].cnt, vecs[0].len, vecs[0].lvl);
    run_pass("busy_ign", 60, 10, 1'b1);
    set_cfg(vecs[1].cnt, vecs[1].len, vecs[1].lvl);
    run_pass("b2b", 21, -1, 1'b0);

    // Asynchronous reset in the middle of a pass.
    set_cfg(vecs[0].cnt, vecs[0].len, vecs[0].lvl);
    launch();
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'({sig, busy, done, seg_idx}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_idle", 64'({sig, busy, done, seg_idx}), 64'(0));
    end

    // Random configurations, some started back-to-back.
    for (int r = 0; r < 25; r++) begin
      rc = IW'($urandom_range(0, 10));
      for (int j = 0; j < 8; j++) rl[j*4 +: 4] = 4'($urandom_range(0, 3));
      rv = 8'($urandom);
      set_cfg(rc, rl, rv);
      if (rc == '0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("rand%0d_idle", r), 64'({sig, busy, done, seg_idx}), 64'(0));
      end else begin
        run_pass($sformatf("rand%0d", r), exp_sig.size(), -1, (r % 3) == 0);
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
